// File: rtl/seg_pkg.sv
// Shared constants and the BCD-to-segment lookup for the seven-segment display driver.
package seg_pkg;

   localparam int NUM_DIGITS   = 8;
   localparam int GROUP_DIGITS = 4;

   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DP    = 8'h80;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } conv_state_e;

   function automatic logic [7:0] bcd_to_seg(input logic [3:0] nibble);
      logic [7:0] seg;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Value load handshake and display pin bundle between the core and the display driver.
interface seg_display_driver_if;

   logic [31:0] value;
   logic        value_valid;
   logic        busy;
   logic [7:0]  seg_cs;
   logic [7:0]  seg_data_0;
   logic [7:0]  seg_data_1;

   modport master (
      output value,
      output value_valid,
      input  busy,
      input  seg_cs,
      input  seg_data_0,
      input  seg_data_1
   );

   modport slave (
      input  value,
      input  value_valid,
      output busy,
      output seg_cs,
      output seg_data_0,
      output seg_data_1
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 32 shift cycles turn a 32-bit binary value into 10 BCD digits.
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] bin_in,
   output logic        busy,
   output logic        done,
   output logic [39:0] bcd
);

   conv_state_e state_q, state_d;
   logic [31:0] bin_q, bin_d;
   logic [39:0] bcd_q, bcd_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [39:0] adj;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   // DONE may restart directly so a queued value follows without an idle gap.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      adj     = bcd_q;
      for (int i = 0; i < 10; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d   = bin_in;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_d, bin_d} = {adj[38:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (start) begin
               bin_d   = bin_in;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_driver.sv
// Eight-digit seven-segment driver: BCD conversion, shadow digits and two-group scan.
// Define SEG_LZB_EN to blank leading zero digits.
module seg_display_driver
   import seg_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1000
) (
   input  logic                 sys_clk_in,
   input  logic                 sys_rst,
   seg_display_driver_if.slave  bus
);

   localparam int DWELL = CLK_HZ / SCAN_HZ;
   localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic        conv_start;
   logic        conv_busy;
   logic        conv_done;
   logic [31:0] conv_value;
   logic [39:0] conv_bcd;

   logic                    pending_q, pending_d;
   logic [31:0]             pending_val_q, pending_val_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic                    ovf_q, ovf_d;
   logic [DW-1:0]           dwell_q, dwell_d;
   logic [1:0]              idx_q, idx_d;
   logic [7:0]              seg_cs_q, seg_cs_d;
   logic [7:0]              seg_data_0_q, seg_data_0_d;
   logic [7:0]              seg_data_1_q, seg_data_1_d;

   bin2bcd_seq u_bin2bcd (
      .clk    (sys_clk_in),
      .rst    (sys_rst),
      .start  (conv_start),
      .bin_in (conv_value),
      .busy   (conv_busy),
      .done   (conv_done),
      .bcd    (conv_bcd)
   );

   always_ff @(posedge sys_clk_in) begin
      if (sys_rst) begin
         pending_q     <= 1'b0;
         pending_val_q <= '0;
         shadow_q      <= '0;
         ovf_q         <= 1'b0;
         dwell_q       <= '0;
         idx_q         <= '0;
         seg_cs_q      <= '0;
         seg_data_0_q  <= '0;
         seg_data_1_q  <= '0;
      end else begin
         pending_q     <= pending_d;
         pending_val_q <= pending_val_d;
         shadow_q      <= shadow_d;
         ovf_q         <= ovf_d;
         dwell_q       <= dwell_d;
         idx_q         <= idx_d;
         seg_cs_q      <= seg_cs_d;
         seg_data_0_q  <= seg_data_0_d;
         seg_data_1_q  <= seg_data_1_d;
      end
   end

   // A strobe arriving during DONE is folded straight into the restart, newest value first.
   always_comb begin
      conv_start    = conv_done ? (pending_q | bus.value_valid) : (~conv_busy & bus.value_valid);
      conv_value    = bus.value_valid ? bus.value : pending_val_q;
      pending_d     = pending_q;
      pending_val_d = pending_val_q;
      if (conv_start) begin
         pending_d = 1'b0;
      end else if (bus.value_valid) begin
         pending_d     = 1'b1;
         pending_val_d = bus.value;
      end
      shadow_d = shadow_q;
      ovf_d    = ovf_q;
      if (conv_done) begin
         shadow_d = conv_bcd[4*NUM_DIGITS-1:0];
         ovf_d    = |conv_bcd[39:4*NUM_DIGITS];
      end
   end

   always_comb begin
      dwell_d = dwell_q + DW'(1);
      idx_d   = idx_q;
      if (dwell_q == DW'(DWELL - 1)) begin
         dwell_d = '0;
         idx_d   = (idx_q == 2'(GROUP_DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
      end
   end

`ifdef SEG_LZB_EN
   logic [NUM_DIGITS-1:0] blank;
   logic                  lead_zero;

   // A digit is blank only if it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      blank     = '0;
      lead_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         lead_zero = lead_zero & (shadow_q[4*i +: 4] == 4'd0);
         blank[i]  = lead_zero;
      end
   end
`endif

   always_comb begin
      seg_cs_d                = '0;
      seg_cs_d[{1'b0, idx_q}] = 1'b1;
      seg_cs_d[{1'b1, idx_q}] = 1'b1;
      seg_data_0_d = bcd_to_seg(shadow_q[{1'b0, idx_q, 2'b00} +: 4]);
      seg_data_1_d = bcd_to_seg(shadow_q[{1'b1, idx_q, 2'b00} +: 4]);
`ifdef SEG_LZB_EN
      if (blank[{1'b0, idx_q}]) begin
         seg_data_0_d = SEG_BLANK;
      end
      if (blank[{1'b1, idx_q}]) begin
         seg_data_1_d = SEG_BLANK;
      end
`endif
      if (ovf_q && (idx_q == 2'(GROUP_DIGITS - 1))) begin
         seg_data_1_d = seg_data_1_d | SEG_DP;
      end
   end

   assign bus.busy       = conv_busy;
   assign bus.seg_cs     = seg_cs_q;
   assign bus.seg_data_0 = seg_data_0_q;
   assign bus.seg_data_1 = seg_data_1_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver with a 10-cycle digit dwell.
module tb_seg_display_driver;

   typedef logic [7:0][7:0] pats_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   pats_t expQ[$];

   seg_display_driver_if bus ();

   seg_display_driver #(
      .CLK_HZ  (1000),
      .SCAN_HZ (100)
   ) dut (
      .sys_clk_in (clk),
      .sys_rst    (rst),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] segOf(input int d);
      case (d)
         0: return 8'h3F;
         1: return 8'h06;
         2: return 8'h5B;
         3: return 8'h4F;
         4: return 8'h66;
         5: return 8'h6D;
         6: return 8'h7D;
         7: return 8'h07;
         8: return 8'h7F;
         default: return 8'h6F;
      endcase
   endfunction

   // Independent decimal model of what each of the eight digits should show.
   function automatic pats_t model(input logic [31:0] v);
      longint unsigned t = 64'(v);
      bit ovf = (t > 64'd99999999);
      int d[8];
      int msd = 0;
      pats_t p;
      for (int i = 0; i < 8; i++) begin
         d[i] = int'(t % 64'd10);
         t    = t / 64'd10;
      end
      for (int i = 0; i < 8; i++) begin
         if (d[i] != 0) msd = i;
      end
      for (int i = 0; i < 8; i++) begin
         p[i] = segOf(d[i]);
`ifdef SEG_LZB_EN
         if (i > msd) p[i] = 8'h00;
`endif
      end
      if (ovf) p[7] = p[7] | 8'h80;
      return p;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] v);
      bus.value       = v;
      bus.value_valid = 1'b1;
      tick();
      bus.value_valid = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int expLen);
      int n = 0;
      while (bus.busy && n < 200) begin
         n++;
         tick();
      end
      checkOutput({tag, " busy cycles"}, 32'(n), 32'(expLen));
   endtask

   // Pops the next expected frame and walks all four scan positions.
   task automatic checkScan(input string tag);
      pats_t exp;
      logic [7:0] cs;
      exp = expQ.pop_front();
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         cs = 8'h00;
         cs[k] = 1'b1;
         cs[k+4] = 1'b1;
         for (int t = 0; t < 60 && bus.seg_cs !== cs; t++) tick();
         checkOutput($sformatf("%s cs k%0d", tag, k), 32'(bus.seg_cs), 32'(cs));
         checkOutput($sformatf("%s d0 k%0d", tag, k), 32'(bus.seg_data_0), 32'(exp[k]));
         checkOutput($sformatf("%s d1 k%0d", tag, k), 32'(bus.seg_data_1), 32'(exp[k+4]));
      end
   endtask

   // Checks whichever scan position is currently being driven.
   task automatic checkCurrent(input string tag, input pats_t exp);
      int k = -1;
      logic [7:0] cs;
      for (int i = 0; i < 4; i++) begin
         cs = 8'h00;
         cs[i] = 1'b1;
         cs[i+4] = 1'b1;
         if (bus.seg_cs === cs) k = i;
      end
      checkOutput({tag, " cs valid"}, 32'(k >= 0), 32'd1);
      if (k >= 0) begin
         checkOutput({tag, " d0"}, 32'(bus.seg_data_0), 32'(exp[k]));
         checkOutput({tag, " d1"}, 32'(bus.seg_data_1), 32'(exp[k+4]));
      end
   endtask

   initial begin
      int n;
      pats_t exp;
      vectors         = 0;
      miscompares     = 0;
      rst             = 1'b1;
      bus.value       = '0;
      bus.value_valid = 1'b0;

      tick();
      tick();
      tick();
      checkOutput("reset cs", 32'(bus.seg_cs), 32'h00);
      checkOutput("reset d0", 32'(bus.seg_data_0), 32'h00);
      checkOutput("reset d1", 32'(bus.seg_data_1), 32'h00);
      checkOutput("reset busy", 32'(bus.busy), 32'h0);

      rst = 1'b0;
      for (int c = 1; c <= 41; c++) begin
         tick();
         if (c == 1) begin
            checkOutput("first cs", 32'(bus.seg_cs), 32'h11);
            checkOutput("first d0", 32'(bus.seg_data_0), 32'h3F);
            checkOutput("first d1", 32'(bus.seg_data_1), 32'h3F);
         end
         if (c == 10) checkOutput("scan c10", 32'(bus.seg_cs), 32'h11);
         if (c == 11) checkOutput("scan c11", 32'(bus.seg_cs), 32'h22);
         if (c == 21) checkOutput("scan c21", 32'(bus.seg_cs), 32'h44);
         if (c == 31) checkOutput("scan c31", 32'(bus.seg_cs), 32'h88);
         if (c == 41) checkOutput("scan c41", 32'(bus.seg_cs), 32'h11);
      end

      $display("[TB] single conversions");
      expQ.push_back(model(32'd12345678));
      applyStimulus(32'd12345678);
      waitDone("12345678", 33);
      checkScan("12345678");

      expQ.push_back(model(32'hFFFFFFFF));
      applyStimulus(32'hFFFFFFFF);
      waitDone("ffffffff", 33);
      checkScan("ffffffff");

      expQ.push_back(model(32'd99999999));
      applyStimulus(32'd99999999);
      waitDone("99999999", 33);
      checkScan("99999999");

      expQ.push_back(model(32'd100000000));
      applyStimulus(32'd100000000);
      waitDone("100000000", 33);
      checkScan("100000000");

      expQ.push_back(model(32'd42));
      applyStimulus(32'd42);
      waitDone("42", 33);
      checkScan("42");

      expQ.push_back(model(32'd0));
      applyStimulus(32'd0);
      waitDone("zero", 33);
      checkScan("zero");

      $display("[TB] pending strobes");
      expQ.push_back(model(32'd5));
      applyStimulus(32'd5);
      n = 0;
      for (int c = 0; c < 200; c++) begin
         if (!bus.busy) break;
         n++;
         if (c == 50) begin
            exp = expQ.pop_front();
            checkCurrent("pending first", exp);
         end
         if (c == 9) begin
            bus.value = 32'd7;
            bus.value_valid = 1'b1;
            expQ.push_back(model(32'd7));
         end
         if (c == 19) begin
            bus.value = 32'd9;
            bus.value_valid = 1'b1;
            void'(expQ.pop_back());
            expQ.push_back(model(32'd9));
         end
         tick();
         bus.value_valid = 1'b0;
      end
      checkOutput("pending busy cycles", 32'(n), 32'd66);
      checkScan("pending last");

      $display("[TB] reset mid-conversion");
      expQ.push_back(model(32'd99));
      applyStimulus(32'd99);
      for (int c = 1; c < 15; c++) tick();
      rst = 1'b1;
      void'(expQ.pop_back());
      tick();
      checkOutput("midrst busy", 32'(bus.busy), 32'h0);
      checkOutput("midrst cs", 32'(bus.seg_cs), 32'h00);
      checkOutput("midrst d0", 32'(bus.seg_data_0), 32'h00);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 50; c++) tick();
      checkOutput("postrst busy", 32'(bus.busy), 32'h0);
      expQ.push_back(model(32'd0));
      checkScan("postrst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
